// File: rtl/sram_controller.sv
// Burst initiator for the 32768 x 32 single-port SRAM: command handshake in, SRAM pin drive out.
// Optional feature macro: SRAM_CTRL_BURST_EN (undefined -> every command is a single beat).
module sram_controller #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]     req_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     done,
  output logic                     mem_enable,
  output logic                     mem_readWrite,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]     r_count;
  logic                     r_rd_valid;
  logic                     r_done;

  logic [LEN_WIDTH-1:0]     w_start_count;
  logic                     w_wr_beat;
  logic                     w_rd_beat;
  logic                     w_last;

`ifdef SRAM_CTRL_BURST_EN
  assign w_start_count = req_len;
`else
  // Length field is kept on the port for drop-in compatibility but has no effect.
  logic w_unused_len;
  assign w_unused_len  = ^req_len;
  assign w_start_count = '0;
`endif

  assign w_wr_beat = (r_state == S_WRITE) && wr_valid;
  assign w_rd_beat = (r_state == S_READ);
  assign w_last    = (r_count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // rd_valid lines up with the SRAM's one-cycle registered read data.
      r_rd_valid <= w_rd_beat;
      r_done     <= (w_wr_beat || w_rd_beat) && w_last;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_count <= w_start_count;
            r_state <= req_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            r_addr  <= r_addr + ADDRESS_WIDTH'(1);
            r_count <= r_count - LEN_WIDTH'(1);
            if (w_last) r_state <= S_IDLE;
          end
        end
        S_READ: begin
          r_addr  <= r_addr + ADDRESS_WIDTH'(1);
          r_count <= r_count - LEN_WIDTH'(1);
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign wr_ready      = (r_state == S_WRITE);
  assign mem_enable    = w_wr_beat || w_rd_beat;
  assign mem_readWrite = (r_state != S_WRITE);
  assign mem_address   = r_addr;
  assign mem_dataIn    = (r_state == S_WRITE) ? wr_data : '0;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_valid ? mem_dataOut : '0;
  assign done          = r_done;

endmodule

// File: doc/sram_controller.md
# sram_controller

Bus-side initiator for the 32768 x 32 single-port SRAM. Accepts read/write burst commands over a valid/ready handshake, drives the SRAM's enable/readWrite/address/dataIn pins, and returns read data with a strobe. Sits between the core's load/store path and the SRAM instance; it is the only master of the SRAM pins.

## Interface

- ADDRESS_WIDTH, 15, SRAM word-address width
- DATA_WIDTH, 32, data word width
- LEN_WIDTH, 8, burst-length field width; beats = req_len + 1 (1..256)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  controller can accept a command
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDRESS_WIDTH  start word address
- req_len  in  LEN_WIDTH  beats minus one
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_WIDTH  write beat data
- rd_valid  out  1  read beat valid (no backpressure)
- rd_data  out  DATA_WIDTH  read beat data
- done  out  1  one-cycle pulse when a burst completes
- mem_enable  out  1  to SRAM enable
- mem_readWrite  out  1  to SRAM readWrite (1 = read, 0 = write)
- mem_address  out  ADDRESS_WIDTH  to SRAM address
- mem_dataIn  out  DATA_WIDTH  to SRAM dataIn
- mem_dataOut  in  DATA_WIDTH  from SRAM dataOut (registered, 1-cycle latency)

## Operation

- States: IDLE, WRITE, READ, DRAIN.
- IDLE: req_ready = 1. On req_valid: latch addr <= req_addr, count <= req_len; go WRITE if req_write else READ. Command transfers only on req_valid & req_ready.
- WRITE: wr_ready = 1; mem_enable = wr_valid; mem_readWrite = 0; mem_dataIn = wr_data. Each accepted beat: addr += 1, count -= 1. Beat with count == 0 -> IDLE, done pulse next cycle. wr_valid low inserts bubbles, no SRAM access.
- READ: mem_enable = 1, mem_readWrite = 1 every cycle; addr += 1, count -= 1 per beat. Beat with count == 0 -> DRAIN.
- DRAIN: mem_enable = 0; captures final beat; -> IDLE.
- rd_valid is a register set in the cycle after a read beat is issued; rd_data = mem_dataOut while rd_valid = 1, else 0.
- done asserts with the last rd_valid (read) or the cycle after the last write beat (write).
- mem_address always = addr register; mem_readWrite = 1 and mem_dataIn = 0 outside WRITE; mem_enable = 0 in IDLE and DRAIN.
- Address arithmetic modulo 2^ADDRESS_WIDTH: 0x7FFF + 1 wraps to 0x0000 within a burst.
- wr_ready = 0 and wr_valid ignored outside WRITE; req_ready = 0 outside IDLE.

## Timing

- Reset: state = IDLE, addr = 0, count = 0; req_ready = 1, wr_ready = 0, rd_valid = 0, rd_data = 0, done = 0, mem_enable = 0, mem_readWrite = 1, mem_address = 0, mem_dataIn = 0.
- Reset mid-burst: next cycle is IDLE; remaining beats abandoned, in-flight read beat discarded (rd_valid = 0), no done.
- Command accepted in cycle T: first SRAM access in T+1.
- Read burst of N beats: issues T+1..T+N; rd_valid T+2..T+N+1; done at T+N+1; req_ready back at T+N+2.
- Write burst, wr_valid held high: writes T+1..T+N; done and req_ready at T+N+1.
- Throughput: one beat per cycle; one idle cycle minimum between bursts.

## Configuration

- SRAM_CTRL_BURST_EN defined: req_len honoured as above.
- Undefined: req_len ignored, every command is a single beat (count forced to 0); LEN_WIDTH port kept, unused.

## Test plan

- Reset, then write 1 beat addr 0x0010 data 0xDEADBEEF; read 1 beat 0x0010 -> rd_valid one cycle at T+2, rd_data 0xDEADBEEF, done same cycle.
- Write burst addr 0x0100 len 3, data 0x1..0x4 with wr_valid low on 2nd cycle -> 4 SRAM writes at 0x100..0x103, one bubble, done after 4th beat; read-back returns 0x1..0x4 on consecutive cycles.
- Read burst addr 0x7FFE len 3 -> mem_address 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- req_valid held high during a burst -> req_ready = 0, second command accepted only in IDLE, exactly one done per burst.
- Reset asserted mid read burst (beat 2 of 8) -> next cycle IDLE, mem_enable 0, rd_valid 0, no done; new command then works.
- Build without SRAM_CTRL_BURST_EN, read req_len 7 -> exactly one beat, done at T+2.
